mux4_rr_arbiter: RTL and testbench
==================================

Name: mux4_rr_arbiter

Overview:
Round-robin arbiter that shares one 4:1 mux datapath between four single-bit requesters. It registers a one-hot grant and drives the mux select, so at most one requester's data reaches the shared output at a time. It sits directly in front of the 4:1 mux and is the block that sequences its select lines.

Parameters:
HOLD_MAX, 8, maximum consecutive grant cycles per requester; used only when MUX_ARB_HOLD_LIMIT_EN is defined; legal range 1..15.
CNT_W, 4, width of the hold counter; must satisfy 2**CNT_W > HOLD_MAX.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
req  input  4  request per requester; req[i] belongs to requester i.
d  input  4  data bit per requester; d[i] is requester i's datapath input.
gnt  output  4  registered one-hot grant; all zero when idle.
sel  output  2  registered mux select; equals the index of the granted requester.
busy  output  1  high while in GRANT.
f  output  1  shared datapath output: d[sel] when busy, else 0 (combinational).

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately):
  - state=IDLE, gnt=4'b0000, sel=2'b00, busy=0, f=0.
  - Priority pointer ptr=0 (requester 0 highest). Hold counter=0.
- States:
  - IDLE: no grant held.
  - GRANT: exactly one gnt bit set.
- Priority search: the candidates are examined in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4). The first index with req set wins.
- IDLE -> GRANT: at the first edge where req != 0.
  - gnt/sel/busy update at that edge, so latency is 1 cycle from req to gnt.
  - ptr is unchanged on entry.
- In GRANT with index g:
  - Grant is held while req[g]=1 (and the hold limit is not reached, see Optional Feature).
  - Release occurs at the edge where req[g]=0. At that edge ptr <= (g+1) mod 4.
  - If any other req bit is set at the release edge, a new grant is issued at that same edge, searched from the new ptr. The transition is GRANT->GRANT with no idle cycle between grants.
  - If no req bit is set at the release edge, the transition is to IDLE: gnt=0, busy=0, and sel holds g.
- While busy, sel changes only on a grant change. While idle, sel holds its last value.
- Simultaneous requests: resolved solely by ptr; there is no fixed priority.
- Requests from non-granted requesters arriving mid-grant are ignored until the release edge.
- A glitch in req bits other than the granted one has no effect.
- Reset asserted mid-grant: outputs go to their reset values immediately, and ptr returns to 0.
- f is purely combinational from d and sel, gated by busy. It has no added latency relative to sel.
- gnt is never multi-hot. sel and gnt are always consistent whenever busy=1.

Optional Feature:
Macro MUX_ARB_HOLD_LIMIT_EN.
- Defined:
  - A CNT_W-bit counter clears on every new grant and increments each cycle in GRANT.
  - When the counter reaches HOLD_MAX-1 while req[g] is still 1, a forced release occurs at the next edge.
  - A forced release behaves exactly like a normal release: ptr <= g+1, and arbitration continues from there. This includes requester g re-winning if it is the only requester.
  - Result: no requester holds the grant for more than HOLD_MAX consecutive cycles.
- Undefined: there is no counter, and a grant is held indefinitely while req[g]=1. HOLD_MAX and CNT_W are unused.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, then release with req=0000 -> gnt=0000, sel=00, busy=0, f=0 throughout.
- Single request latency: req=0100, d=0100 -> gnt=0100 and sel=10 one edge later, busy=1, f=1. Drop req -> gnt=0000 next edge, sel stays 10.
- Round-robin fairness: req=1111 held, with each granted requester dropping its req bit for 1 cycle after 2 cycles of grant and then re-raising it -> grant order 0,1,2,3,0 with no idle cycle between grants.
- Pointer after release: grant requester 2, release it while req=0011 -> next grant is 0 (search order 3,0,1,2), sel=00.
- Async reset mid-grant: gnt=1000, pull rst_n low between edges -> gnt=0000, busy=0 immediately. After release with req=0110 -> grant is 1 (ptr=0).
- With MUX_ARB_HOLD_LIMIT_EN and HOLD_MAX=3: req=0011 held constantly -> grant alternates 0,1,0,1 with each grant lasting exactly 3 cycles. Repeat without the macro -> requester 0 holds the grant indefinitely.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux4_rr_arbiter
//   Round-robin arbiter that owns the select lines of a shared 4:1 mux. Four
//   single-bit requesters compete; the winner gets a registered one-hot grant,
//   the mux select follows it, and only that requester's data bit reaches f.
//
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   req    request per requester (req[i] -> requester i)
//   d      data bit per requester (d[i] -> requester i)
//   gnt    registered one-hot grant, zero when idle
//   sel    registered mux select, index of the granted requester
//   busy   high while a grant is held
//   f      shared output: d[sel] when busy, else 0 (combinational)
//
// Parameters
//   HOLD_MAX  max consecutive grant cycles per requester (1..15)
//   CNT_W     hold counter width, 2**CNT_W > HOLD_MAX
//
// Build option
//   MUX_ARB_HOLD_LIMIT_EN  when defined, a grant is forcibly released after
//                          HOLD_MAX cycles; otherwise it is held as long as
//                          the owner keeps requesting.
// -----------------------------------------------------------------------------
module mux4_rr_arbiter #(
   parameter int HOLD_MAX = 8,
   parameter int CNT_W    = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   input  logic [3:0] d,
   output logic [3:0] gnt,
   output logic [1:0] sel,
   output logic       busy,
   output logic       f
);

   localparam logic ST_IDLE  = 1'b0;
   localparam logic ST_GRANT = 1'b1;

   if (HOLD_MAX < 1 || HOLD_MAX > 15 || (1 << CNT_W) <= HOLD_MAX) begin : g_cfg_err
      $error("mux4_rr_arbiter: HOLD_MAX must be 1..15 and fit in CNT_W bits");
   end

   logic       state;
   logic [1:0] ptr;
   logic       rel;      // current grant ends at this edge
   logic       ld;       // a new grant is issued at this edge
   logic [1:0] base;     // first index examined by the search
   logic [1:0] idx;
   logic       found;
   logic [1:0] win;

`ifdef MUX_ARB_HOLD_LIMIT_EN
   logic [CNT_W-1:0] cnt;
   logic             hold_hit;

   assign hold_hit = (cnt == CNT_W'(HOLD_MAX - 1));
   assign rel      = (state == ST_GRANT) && (!req[sel] || hold_hit);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (ld)
         cnt <= '0;
      else if (state == ST_GRANT)
         cnt <= cnt + CNT_W'(1);
   end
`else
   assign rel = (state == ST_GRANT) && !req[sel];
`endif

   // On release the search restarts just past the outgoing owner, so the
   // owner itself is examined last (and can only re-win when alone).
   always_comb begin
      base  = rel ? sel + 2'd1 : ptr;
      found = 1'b0;
      win   = base;
      idx   = base;
      for (int i = 3; i >= 0; i--) begin
         idx = base + 2'(i);
         if (req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   assign ld = found && ((state == ST_IDLE) || rel);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         gnt   <= 4'b0000;
         sel   <= 2'b00;
         ptr   <= 2'b00;
      end else begin
         if (rel)
            ptr <= sel + 2'd1;
         if (ld) begin
            state <= ST_GRANT;
            gnt   <= 4'b0001 << win;
            sel   <= win;
         end else if (rel) begin
            // nobody else waiting: go idle, sel keeps pointing at last owner
            state <= ST_IDLE;
            gnt   <= 4'b0000;
         end
      end
   end

   assign busy = (state == ST_GRANT);
   assign f    = busy & d[sel];

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux4_rr_arbiter
//   Directed-vector bench for mux4_rr_arbiter. Every observation packs
//   {gnt, sel, busy, f} into one byte and compares it to a hand-computed value.
// -----------------------------------------------------------------------------
module tb_mux4_rr_arbiter;

   logic       clk;
   logic       rst_n;
   logic [3:0] req;
   logic [3:0] d;
   logic [3:0] gnt;
   logic [1:0] sel;
   logic       busy;
   logic       f;

   int n_chk;
   int n_err;

   mux4_rr_arbiter #(.HOLD_MAX(3), .CNT_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req),
      .d     (d),
      .gnt   (gnt),
      .sel   (sel),
      .busy  (busy),
      .f     (f)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] ev(input logic [3:0] g, input logic [1:0] s,
                                     input logic b, input logic fo);
      return {g, s, b, fo};
   endfunction

   task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got gnt/sel/busy/f=%b, expected %b", tag, act, exp);
      end
   endtask

   task automatic obs(input string tag, input logic [7:0] exp);
      chk(tag, {gnt, sel, busy, f}, exp);
   endtask

   // advance one rising edge, then settle away from it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // asynchronous pulse between edges; leaves ptr=0 and the block idle
   task automatic do_reset();
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      n_chk = 0;
      n_err = 0;
      rst_n = 1'b0;
      req   = 4'b0000;
      d     = 4'b0000;

      // ---- reset then idle ----
      tick();
      tick();
      obs("reset", ev(4'b0000, 2'b00, 1'b0, 1'b0));
      rst_n = 1'b1;
      tick();
      obs("idle0", ev(4'b0000, 2'b00, 1'b0, 1'b0));
      tick();
      obs("idle1", ev(4'b0000, 2'b00, 1'b0, 1'b0));

      // ---- single request latency ----
      req = 4'b0100;
      d   = 4'b0100;
      #1;
      obs("single_pre_edge", ev(4'b0000, 2'b00, 1'b0, 1'b0));
      tick();
      obs("single_grant", ev(4'b0100, 2'b10, 1'b1, 1'b1));
      d = 4'b1011;                       // f follows d combinationally
      #1;
      obs("single_f_comb", ev(4'b0100, 2'b10, 1'b1, 1'b0));
      d   = 4'b0100;
      req = 4'b0000;
      tick();
      obs("single_release", ev(4'b0000, 2'b10, 1'b0, 1'b0));

      // ---- round-robin fairness, req=1111, owner drops for one cycle ----
      do_reset();
      d   = 4'b1010;
      req = 4'b1111;
      tick();
      obs("rr_first", ev(4'b0001, 2'b00, 1'b1, 1'b0));
      tick();
      obs("rr_hold0", ev(4'b0001, 2'b00, 1'b1, 1'b0));
      req = 4'b1110;
      tick();
      obs("rr_to1", ev(4'b0010, 2'b01, 1'b1, 1'b1));
      req = 4'b1111;
      tick();
      obs("rr_hold1", ev(4'b0010, 2'b01, 1'b1, 1'b1));
      req = 4'b1101;
      tick();
      obs("rr_to2", ev(4'b0100, 2'b10, 1'b1, 1'b0));
      req = 4'b1111;
      tick();
      obs("rr_hold2", ev(4'b0100, 2'b10, 1'b1, 1'b0));
      req = 4'b1011;
      tick();
      obs("rr_to3", ev(4'b1000, 2'b11, 1'b1, 1'b1));
      req = 4'b1111;
      tick();
      obs("rr_hold3", ev(4'b1000, 2'b11, 1'b1, 1'b1));
      req = 4'b0111;
      tick();
      obs("rr_wrap0", ev(4'b0001, 2'b00, 1'b1, 1'b0));
      // glitch on non-owners while 0 holds: no effect
      req = 4'b0001;
      tick();
      obs("glitch_a", ev(4'b0001, 2'b00, 1'b1, 1'b0));
      req = 4'b1111;
      tick();
      obs("glitch_b", ev(4'b0001, 2'b00, 1'b1, 1'b0));
      req = 4'b0000;
      tick();
      obs("rr_idle", ev(4'b0000, 2'b00, 1'b0, 1'b0));

      // ---- pointer after release: 2 releases with req=0011 -> 0 wins ----
      do_reset();
      d   = 4'b0001;
      req = 4'b0100;
      tick();
      obs("ptr_g2", ev(4'b0100, 2'b10, 1'b1, 1'b0));
      req = 4'b0011;
      tick();
      obs("ptr_next0", ev(4'b0001, 2'b00, 1'b1, 1'b1));
      req = 4'b0000;
      tick();
      obs("ptr_idle", ev(4'b0000, 2'b00, 1'b0, 1'b0));

      // ---- async reset mid-grant ----
      do_reset();
      d   = 4'b1000;
      req = 4'b1000;
      tick();
      obs("areset_g3", ev(4'b1000, 2'b11, 1'b1, 1'b1));
      #2;
      rst_n = 1'b0;
      #1;
      obs("areset_now", ev(4'b0000, 2'b00, 1'b0, 1'b0));
      req   = 4'b0110;
      d     = 4'b0010;
      rst_n = 1'b1;
      tick();
      obs("areset_ptr0", ev(4'b0010, 2'b01, 1'b1, 1'b1));
      req = 4'b0000;
      tick();

      // ---- hold limit (HOLD_MAX=3) vs unlimited hold, req=0011 ----
      do_reset();
      d   = 4'b0001;
      req = 4'b0011;
`ifdef MUX_ARB_HOLD_LIMIT_EN
      for (int r = 0; r < 2; r++) begin
         for (int c = 0; c < 3; c++) begin
            tick();
            obs($sformatf("hold_r%0d_g0_c%0d", r, c), ev(4'b0001, 2'b00, 1'b1, 1'b1));
         end
         for (int c = 0; c < 3; c++) begin
            tick();
            obs($sformatf("hold_r%0d_g1_c%0d", r, c), ev(4'b0010, 2'b01, 1'b1, 1'b0));
         end
      end
      // requester 0 alone re-wins after each forced release
      req = 4'b0001;
      tick();
      obs("hold_alone", ev(4'b0001, 2'b00, 1'b1, 1'b1));
      tick();
      tick();
      tick();
      obs("hold_alone_rewin", ev(4'b0001, 2'b00, 1'b1, 1'b1));
`else
      for (int c = 0; c < 10; c++) begin
         tick();
         obs($sformatf("nohold_c%0d", c), ev(4'b0001, 2'b00, 1'b1, 1'b1));
      end
`endif
      req = 4'b0000;
      tick();
      obs("final_idle", ev(4'b0000, 2'b00, 1'b0, 1'b0));

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
